// File: rtl/drive_z_corr_table_loader_pkg.sv
// Shared definitions for the drive-circuit Z-correction table.
// Holds the default geometry, the derived table sizes and the loader
// state encoding, so the table, the loader and their benches all agree.
package drive_z_corr_pkg;

    localparam int DEF_NUM_BANK           = 2;
    localparam int DEF_NUM_QUBIT_PER_BANK = 16;
    localparam int DEF_ADDR_WIDTH         = 4;
    localparam int DEF_Z_CORR_WIDTH       = 12;

    localparam int TOTAL_QUBIT = DEF_NUM_QUBIT_PER_BANK * DEF_NUM_BANK;
    localparam int DATA_WIDTH  = DEF_Z_CORR_WIDTH * TOTAL_QUBIT;
    localparam int NUM_ENTRY   = DEF_NUM_QUBIT_PER_BANK;
    localparam int CNT_WIDTH   = $clog2(TOTAL_QUBIT) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        CLEAR   = 2'd3
    } z_corr_ld_state_t;

endpackage

// File: rtl/drive_z_corr_table_loader_if.sv
// Write port of the Z-correction table memories.
//   wr_sel  : bank select mask (multi-hot = broadcast)
//   wr_en   : single-cycle write strobe; the other fields are only
//             meaningful while wr_en is high
//   wr_addr : entry address within each selected bank
//   wr_data : packed entry, qubit k at [k*Z_CORR_WIDTH +: Z_CORR_WIDTH]
// master = loader (producer), slave = table memories.
interface drive_z_corr_table_loader_if
    import drive_z_corr_pkg::*;
#(
    parameter int NUM_BANK   = DEF_NUM_BANK,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = drive_z_corr_pkg::DATA_WIDTH
) ();

    logic [NUM_BANK-1:0]   wr_sel;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (output wr_sel, output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_sel, input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/drive_z_corr_table_loader_packer.sv
// Serial-to-parallel packer for Z-correction words.
//   clk, rst    : clock, asynchronous active-low reset
//   clr_i       : restart at slot 0 and zero the packing register
//   load_i      : word handshake; word_i goes into slot cnt, cnt advances
//   word_i      : incoming correction word
//   last_word_o : the slot being filled next is the final one
//   pack_nxt_o  : packing register including this cycle's insert, so the
//                 caller can capture a complete entry on the last handshake
module drive_z_corr_word_packer
    import drive_z_corr_pkg::*;
#(
    parameter int WORD_W   = DEF_Z_CORR_WIDTH,
    parameter int NUM_WORD = TOTAL_QUBIT,
    parameter int CNT_W    = $clog2(NUM_WORD) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       load_i,
    input  logic [WORD_W-1:0]          word_i,
    output logic                       last_word_o,
    output logic [NUM_WORD*WORD_W-1:0] pack_nxt_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORD - 1);

    logic [NUM_WORD-1:0][WORD_W-1:0] pack_q, pack_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;

    assign last_word_o = (cnt_q == LAST_CNT);
    assign pack_nxt_o  = pack_d;

    // One insert slot per qubit; only the slot matching the counter loads.
    for (genvar k = 0; k < NUM_WORD; k++) begin : g_slot
        always_comb begin
            pack_d[k] = pack_q[k];
            if (clr_i)
                pack_d[k] = '0;
            else if (load_i && (cnt_q == CNT_W'(k)))
                pack_d[k] = word_i;
        end
    end

    // Wraps to 0 after the last slot so it never exceeds NUM_WORD-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (load_i)
            cnt_d = last_word_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_q <= '0;
            cnt_q  <= '0;
        end else begin
            pack_q <= pack_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/drive_z_corr_table_loader.sv
// Writer side of the drive-circuit Z-correction table.
// Takes a host command (bank mask + entry address), gathers one
// correction word per qubit, packs them and issues one table write.
// A clear command zero-fills every entry of the selected banks.
//   clk, rst       : clock, asynchronous active-low reset
//   start_*        : command handshake (mask, addr, clear flag)
//   word_*         : serial correction words, qubit index = arrival order
//   abort          : cancel an in-progress collect or clear
//   z_corr_memory  : registered table write port (master)
//   done           : pulse with the final write of a command
//   err_mask       : pulse when a command arrives with an empty mask
module drive_z_corr_table_loader
    import drive_z_corr_pkg::*;
#(
    parameter int NUM_BANK                  = DEF_NUM_BANK,
    parameter int NUM_QUBIT_PER_BANK        = DEF_NUM_QUBIT_PER_BANK,
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = DEF_ADDR_WIDTH,
    parameter int Z_CORR_WIDTH              = DEF_Z_CORR_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_valid,
    output logic                                 start_ready,
    input  logic [NUM_BANK-1:0]                  start_mask,
    input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] start_addr,
    input  logic                                 start_clear,
    input  logic                                 word_valid,
    output logic                                 word_ready,
    input  logic [Z_CORR_WIDTH-1:0]              word_data,
    input  logic                                 abort,
    drive_z_corr_table_loader_if.master          z_corr_memory,
    output logic                                 done,
    output logic                                 err_mask
);

    localparam int ADDR_W  = QUBIT_ADDR_WIDTH_PER_BANK;
    localparam int TOT_Q   = NUM_QUBIT_PER_BANK * NUM_BANK;
    localparam int DATA_W  = Z_CORR_WIDTH * TOT_Q;
    localparam int N_ENTRY = NUM_QUBIT_PER_BANK;
    localparam int CNT_W   = $clog2(TOT_Q) + 1;

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_COLLECT = COLLECT;
    localparam logic [1:0] S_WRITE   = WRITE;
    localparam logic [1:0] S_CLEAR   = CLEAR;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ENTRY - 1);

    logic [1:0]          state_q, state_d;
    logic [NUM_BANK-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [NUM_BANK-1:0] wr_sel_q, wr_sel_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                pk_clr;
    logic                word_hs;
    logic                last_word;
    logic [DATA_W-1:0]   pack_nxt;
    logic [ADDR_W-1:0]   addr_inc;

    assign start_ready = (state_q == S_IDLE);
    assign word_ready  = (state_q == S_COLLECT) && !abort;
    assign word_hs     = word_valid && word_ready;
    // wr_addr doubles as the clear address counter.
    assign addr_inc    = wr_addr_q + ADDR_W'(1);

    drive_z_corr_word_packer #(
        .WORD_W   (Z_CORR_WIDTH),
        .NUM_WORD (TOT_Q),
        .CNT_W    (CNT_W)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (pk_clr),
        .load_i      (word_hs),
        .word_i      (word_data),
        .last_word_o (last_word),
        .pack_nxt_o  (pack_nxt)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        wr_sel_d  = wr_sel_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        pk_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    if (start_mask == '0) begin
                        err_d = 1'b1;
                    end else if (start_clear) begin
                        // First clear write goes out with the state change.
                        mask_d    = start_mask;
                        state_d   = S_CLEAR;
                        wr_en_d   = 1'b1;
                        wr_sel_d  = start_mask;
                        wr_addr_d = '0;
                        wr_data_d = '0;
                        done_d    = (N_ENTRY == 1);
                    end else begin
                        mask_d  = start_mask;
                        addr_d  = start_addr;
                        pk_clr  = 1'b1;
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (word_hs && last_word) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_sel_d  = mask_q;
                    wr_addr_d = addr_q;
                    wr_data_d = pack_nxt;
                    done_d    = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                // The write on the bus this cycle stands even on abort.
                if (abort || (wr_addr_q == LAST_ADDR)) begin
                    state_d = S_IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_inc;
                    done_d    = (addr_inc == LAST_ADDR);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            addr_q    <= '0;
            wr_sel_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            wr_sel_q  <= wr_sel_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign z_corr_memory.wr_sel  = wr_sel_q;
    assign z_corr_memory.wr_en   = wr_en_q;
    assign z_corr_memory.wr_addr = wr_addr_q;
    assign z_corr_memory.wr_data = wr_data_q;
    assign done                  = done_q;
    assign err_mask              = err_q;

endmodule

// File: tb/tb_drive_z_corr_table_loader.sv
module tb_drive_z_corr_table_loader;
    import drive_z_corr_pkg::*;

    localparam int NB = 2;
    localparam int NQ = 16;
    localparam int AW = 4;
    localparam int ZW = 12;
    localparam int TQ = NB * NQ;
    localparam int DW = ZW * TQ;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic [NB-1:0] start_mask = '0;
    logic [AW-1:0] start_addr = '0;
    logic          start_clear = 1'b0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic [ZW-1:0] word_data = '0;
    logic          abort = 1'b0;
    logic          done;
    logic          err_mask;

    always #5 clk = ~clk;

    drive_z_corr_table_loader_if #(.NUM_BANK(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) zc ();

    drive_z_corr_table_loader #(
        .NUM_BANK                  (NB),
        .NUM_QUBIT_PER_BANK        (NQ),
        .QUBIT_ADDR_WIDTH_PER_BANK (AW),
        .Z_CORR_WIDTH              (ZW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .start_mask    (start_mask),
        .start_addr    (start_addr),
        .start_clear   (start_clear),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .word_data     (word_data),
        .abort         (abort),
        .z_corr_memory (zc.master),
        .done          (done),
        .err_mask      (err_mask)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Event counters sampled on the falling edge.
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0, wrdy_cnt = 0;
    always @(negedge clk) begin
        if (zc.wr_en === 1'b1)  wr_cnt++;
        if (done === 1'b1)      done_cnt++;
        if (err_mask === 1'b1)  err_cnt++;
        if (word_ready === 1'b1) wrdy_cnt++;
    end

    function automatic logic [DW-1:0] pat(input logic [ZW-1:0] base);
        logic [DW-1:0] p;
        p = '0;
        for (int i = 0; i < TQ; i++) p[i*ZW +: ZW] = base + ZW'(i);
        return p;
    endfunction

    task automatic issue(input logic [NB-1:0] m, input logic [AW-1:0] a, input logic c);
        start_valid = 1'b1;
        start_mask  = m;
        start_addr  = a;
        start_clear = c;
        @(negedge clk);
        start_valid = 1'b0;
        start_clear = 1'b0;
    endtask

    task automatic send(input int n, input logic [ZW-1:0] base, input bit gap);
        for (int i = 0; i < n; i++) begin
            word_valid = 1'b1;
            word_data  = base + ZW'(i);
            @(negedge clk);
            if (gap && i != n - 1) begin
                word_valid = 1'b0;
                @(negedge clk);
            end
        end
        word_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int w0, d0, e0, r0;

    initial begin
        #1 rst = 1'b0;
        #2;
        chk("rst_wr_en",   zc.wr_en,   '0);
        chk("rst_wr_sel",  zc.wr_sel,  '0);
        chk("rst_wr_addr", zc.wr_addr, '0);
        chk("rst_wr_data", zc.wr_data, '0);
        chk("rst_done",    done,       '0);
        chk("rst_err",     err_mask,   '0);
        chk("rst_sready",  start_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single gap-free load.
        w0 = wr_cnt; d0 = done_cnt;
        issue(2'b01, 4'd5, 1'b0);
        chk("ld_wready", word_ready, 1);
        chk("ld_sready", start_ready, 0);
        send(32, 12'h001, 1'b0);
        chk("ld_wr_en",   zc.wr_en, 1);
        chk("ld_sel",     zc.wr_sel, 2'b01);
        chk("ld_addr",    zc.wr_addr, 4'd5);
        chk("ld_lo",      zc.wr_data[11:0], 12'h001);
        chk("ld_hi",      zc.wr_data[383:372], 12'h020);
        chk("ld_data",    zc.wr_data, pat(12'h001));
        chk("ld_done",    done, 1);
        chk("ld_sready1", start_ready, 0);
        @(negedge clk);
        chk("ld_wr_en0",  zc.wr_en, 0);
        chk("ld_sready2", start_ready, 1);
        chk("ld_hold",    zc.wr_data, pat(12'h001));
        @(negedge clk);
        chk("ld_nwr",     wr_cnt - w0, 1);
        chk("ld_ndone",   done_cnt - d0, 1);

        // Broadcast with gaps between words.
        issue(2'b11, 4'd15, 1'b0);
        send(16, 12'h001, 1'b1);
        chk("bc_sready_mid", start_ready, 0);
        word_valid = 1'b0;
        @(negedge clk);
        send(16, 12'h011, 1'b1);
        chk("bc_wr_en",   zc.wr_en, 1);
        chk("bc_sel",     zc.wr_sel, 2'b11);
        chk("bc_addr",    zc.wr_addr, 4'd15);
        chk("bc_data",    zc.wr_data, pat(12'h001));
        chk("bc_sready1", start_ready, 0);
        @(negedge clk);
        chk("bc_sready2", start_ready, 1);
        chk("bc_wr_en0",  zc.wr_en, 0);

        // Clear of bank 1.
        @(negedge clk);
        w0 = wr_cnt; d0 = done_cnt;
        issue(2'b10, 4'd9, 1'b1);
        for (int i = 0; i < NQ; i++) begin
            chk($sformatf("clr_en%0d", i),   zc.wr_en, 1);
            chk($sformatf("clr_addr%0d", i), zc.wr_addr, DW'(i));
            chk($sformatf("clr_data%0d", i), zc.wr_data, '0);
            chk($sformatf("clr_sel%0d", i),  zc.wr_sel, 2'b10);
            chk($sformatf("clr_done%0d", i), done, DW'(i == NQ - 1));
            @(negedge clk);
        end
        chk("clr_en_end",  zc.wr_en, 0);
        chk("clr_sready",  start_ready, 1);
        chk("clr_hold",    zc.wr_addr, 4'd15);
        @(negedge clk);
        chk("clr_nwr",     wr_cnt - w0, 16);
        chk("clr_ndone",   done_cnt - d0, 1);

        // Abort after 10 words, word offered alongside abort is dropped.
        w0 = wr_cnt; d0 = done_cnt;
        issue(2'b01, 4'd3, 1'b0);
        send(10, 12'h100, 1'b0);
        abort = 1'b1;
        word_valid = 1'b1;
        word_data = 12'habc;
        #1;
        chk("ab_wready", word_ready, 0);
        @(negedge clk);
        abort = 1'b0;
        word_valid = 1'b0;
        chk("ab_sready", start_ready, 1);
        chk("ab_wr_en",  zc.wr_en, 0);
        repeat (3) @(negedge clk);
        chk("ab_nwr",    wr_cnt - w0, 0);
        chk("ab_ndone",  done_cnt - d0, 0);
        issue(2'b01, 4'd7, 1'b0);
        send(32, 12'h200, 1'b0);
        chk("ab_ld_en",   zc.wr_en, 1);
        chk("ab_ld_addr", zc.wr_addr, 4'd7);
        chk("ab_ld_data", zc.wr_data, pat(12'h200));
        @(negedge clk);
        @(negedge clk);

        // Empty mask.
        w0 = wr_cnt; e0 = err_cnt; r0 = wrdy_cnt;
        issue(2'b00, 4'd2, 1'b0);
        chk("zm_err",    err_mask, 1);
        chk("zm_sready", start_ready, 1);
        chk("zm_wready", word_ready, 0);
        @(negedge clk);
        chk("zm_err0",   err_mask, 0);
        repeat (3) @(negedge clk);
        chk("zm_nerr",   err_cnt - e0, 1);
        chk("zm_nwr",    wr_cnt - w0, 0);
        chk("zm_nwrdy",  wrdy_cnt - r0, 0);

        // Reset in the middle of a collect.
        issue(2'b11, 4'd9, 1'b0);
        send(20, 12'h300, 1'b0);
        w0 = wr_cnt;
        #2 rst = 1'b0;
        #1;
        chk("mr_wr_en",   zc.wr_en, 0);
        chk("mr_wr_sel",  zc.wr_sel, '0);
        chk("mr_wr_addr", zc.wr_addr, '0);
        chk("mr_wr_data", zc.wr_data, '0);
        chk("mr_done",    done, 0);
        chk("mr_err",     err_mask, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("mr_nwr",     wr_cnt - w0, 0);
        chk("mr_sready",  start_ready, 1);
        chk("mr_wready",  word_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
